// File: rtl/video_source_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// video_source_arbiter_if : Avalon-ST Video beat bus, ready latency 1 | Rev 1.0
// ----------------------------------------------------------------------------
interface video_source_arbiter_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              sop;
    logic              eop;
    logic              ready;

    modport master (output data, valid, sop, eop, input  ready);
    modport slave  (input  data, valid, sop, eop, output ready);
endinterface
`default_nettype wire

// File: rtl/video_source_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// video_source_arbiter : frame-boundary 2:1 Avalon-ST Video arbiter     | Rev 1.0
// ----------------------------------------------------------------------------
module video_source_arbiter #(
    parameter int DATA_W          = 24,
    parameter int FRAMES_PER_SLOT = 1
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic                  cfg_enable,
    input  wire logic                  cfg_mode,
    input  wire logic                  cfg_sel,
    video_source_arbiter_if.slave      s0,
    video_source_arbiter_if.slave      s1,
    video_source_arbiter_if.master     m,
    output logic                       active_src,
    output logic                       busy,
    output logic [15:0]                frame_count
);

    localparam logic [7:0] C_FPS = 8'(FRAMES_PER_SLOT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_grant;
    logic        r_in_video;
    logic [7:0]  r_slot_cnt;
    logic        r_alt_ptr;
    logic [15:0] r_frame_count;

    logic [DATA_W-1:0] w_data;
    logic              w_valid;
    logic              w_sop;
    logic              w_eop;
    logic              w_fwd;
    logic              w_beat;
    logic              w_pass_rdy;
    logic              w_is_video_sop;
    logic              w_in_video_eff;
    logic              w_frame_done;
    logic [7:0]        w_slot_inc;
    logic              w_alt_flip;
    logic              w_alt_next;
    logic              w_target;
    logic              w_target_next;

    always_comb begin
        w_data  = r_grant ? s1.data  : s0.data;
        w_valid = r_grant ? s1.valid : s0.valid;
        w_sop   = r_grant ? s1.sop   : s0.sop;
        w_eop   = r_grant ? s1.eop   : s0.eop;
    end

    // Beats are forwarded in DRAIN too: they were requested by last cycle's ready.
    assign w_fwd      = (r_state != ST_IDLE);
    assign w_beat     = w_fwd & w_valid;
    assign w_pass_rdy = (r_state == ST_PASS) & m.ready;

    assign m.data  = w_fwd ? w_data : '0;
    assign m.valid = w_beat;
    assign m.sop   = w_fwd & w_sop;
    assign m.eop   = w_fwd & w_eop;

    assign s0.ready = w_pass_rdy & ~r_grant;
    assign s1.ready = w_pass_rdy &  r_grant;

    // A single-beat packet carries sop and eop together, so classify it on the fly.
    assign w_is_video_sop = w_sop & (w_data[3:0] == 4'd0);
    assign w_in_video_eff = w_sop ? w_is_video_sop : r_in_video;
    assign w_frame_done   = w_beat & w_eop & w_in_video_eff;

    assign w_slot_inc    = r_slot_cnt + 8'd1;
    assign w_alt_flip    = cfg_mode & (w_slot_inc == C_FPS);
    assign w_alt_next    = w_alt_flip ? ~r_grant : r_alt_ptr;
    assign w_target      = cfg_mode ? r_alt_ptr  : cfg_sel;
    assign w_target_next = cfg_mode ? w_alt_next : cfg_sel;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= 1'b0;
            r_in_video    <= 1'b0;
            r_slot_cnt    <= 8'd0;
            r_alt_ptr     <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            if (w_beat) begin
                if (w_sop) begin
                    r_in_video <= w_is_video_sop;
                end
                if (w_frame_done) begin
                    r_in_video    <= 1'b0;
                    r_frame_count <= r_frame_count + 16'd1;
                    r_slot_cnt    <= w_slot_inc;
                    if (w_alt_flip) begin
                        r_alt_ptr <= ~r_grant;
                    end
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (cfg_enable) begin
                        r_grant    <= w_target;
                        r_slot_cnt <= 8'd0;
                        r_state    <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (w_frame_done && (!cfg_enable || (w_target_next != r_grant))) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // A new packet already started by the current source keeps the grant.
                    if (w_beat && w_sop && !w_frame_done) begin
                        r_state <= ST_PASS;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign active_src  = r_grant;
    assign busy        = (r_state != ST_IDLE);
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_video_source_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_video_source_arbiter : randomized bench with packet-level reference  | Rev 1.0
// ----------------------------------------------------------------------------
module tb_video_source_arbiter;

    localparam int FPS = 2;

    typedef struct packed {
        logic [23:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_enable;
    logic        cfg_mode;
    logic        cfg_sel;
    logic        active_src;
    logic        busy;
    logic [15:0] frame_count;

    video_source_arbiter_if #(.DATA_W(24)) s0_if ();
    video_source_arbiter_if #(.DATA_W(24)) s1_if ();
    video_source_arbiter_if #(.DATA_W(24)) m_if  ();

    video_source_arbiter #(.DATA_W(24), .FRAMES_PER_SLOT(FPS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_enable  (cfg_enable),
        .cfg_mode    (cfg_mode),
        .cfg_sel     (cfg_sel),
        .s0          (s0_if),
        .s1          (s1_if),
        .m           (m_if),
        .active_src  (active_src),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    beat_t q0[$], q1[$], exp_q[$], out_q[$], pkt[$];
    beat_t drv_b0, drv_b1;
    int    gap0, gap1, gcnt0, gcnt1;
    int    out_cnt;
    int    checks = 0;
    int    errors = 0;
    logic  rdy0_seen = 1'b0, rdy1_seen = 1'b0;
    bit    bp_en = 1'b0;
    bit    both_rdy, s1_rdy_any, drain_beat;

    // Source models: a beat may go out only in the cycle after ready was seen high.
    always @(posedge clk) begin
        #1;
        if (gcnt0 > 0) begin
            gcnt0--; s0_if.valid = 1'b0;
        end else if (rdy0_seen && q0.size() > 0) begin
            drv_b0 = q0.pop_front();
            s0_if.data = drv_b0.data; s0_if.sop = drv_b0.sop; s0_if.eop = drv_b0.eop; s0_if.valid = 1'b1;
            if (drv_b0.eop) gcnt0 = gap0;
        end else begin
            s0_if.valid = 1'b0; s0_if.sop = 1'b0; s0_if.eop = 1'b0; s0_if.data = '0;
        end
        if (gcnt1 > 0) begin
            gcnt1--; s1_if.valid = 1'b0;
        end else if (rdy1_seen && q1.size() > 0) begin
            drv_b1 = q1.pop_front();
            s1_if.data = drv_b1.data; s1_if.sop = drv_b1.sop; s1_if.eop = drv_b1.eop; s1_if.valid = 1'b1;
            if (drv_b1.eop) gcnt1 = gap1;
        end else begin
            s1_if.valid = 1'b0; s1_if.sop = 1'b0; s1_if.eop = 1'b0; s1_if.data = '0;
        end
        if (bp_en) m_if.ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        rdy0_seen = s0_if.ready;
        rdy1_seen = s1_if.ready;
        if (s0_if.ready && s1_if.ready) both_rdy = 1'b1;
        if (s1_if.ready) s1_rdy_any = 1'b1;
        if (m_if.valid) begin
            out_q.push_back({m_if.data, m_if.sop, m_if.eop});
            out_cnt++;
            if (busy && m_if.ready && !s0_if.ready && !s1_if.ready) drain_beat = 1'b1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; cfg_enable = 1'b0; cfg_mode = 1'b0; cfg_sel = 1'b0;
        bp_en = 1'b0; m_if.ready = 1'b1;
        tick(); tick();
        reset_n = 1'b1;
        q0.delete(); q1.delete(); exp_q.delete(); out_q.delete(); out_cnt = 0;
        gap0 = 0; gap1 = 0; gcnt0 = 0; gcnt1 = 0;
        both_rdy = 1'b0; s1_rdy_any = 1'b0; drain_beat = 1'b0;
    endtask

    task automatic gen_pkt(input bit src, input logic [3:0] typ, input int len);
        beat_t b;
        pkt.delete();
        for (int i = 0; i < len; i++) begin
            b.data = {src, 19'($urandom), 4'($urandom)};
            if (i == 0) b.data[3:0] = typ;
            b.sop = (i == 0);
            b.eop = (i == len - 1);
            pkt.push_back(b);
        end
    endtask

    // Queue the last generated packet on its source and append it to the expected output.
    task automatic push_pkt(input bit src);
        foreach (pkt[i]) begin
            if (src) q1.push_back(pkt[i]); else q0.push_back(pkt[i]);
            exp_q.push_back(pkt[i]);
        end
    endtask

    task automatic wait_out(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            if (out_cnt >= n) begin ok = 1'b1; break; end
            @(posedge clk);
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (out_q[i] !== exp_q[i]) return i;
        if (out_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic test_reset();
        do_reset();
        tick(); tick();
        @(negedge clk);
        checks++;
        if ({m_if.valid, m_if.sop, m_if.eop} !== 3'b000 || m_if.data !== 24'd0) begin
            errors++; $display("FAIL reset_m got v/s/e=%b%b%b data=%h exp 000 000000", m_if.valid, m_if.sop, m_if.eop, m_if.data);
        end
        checks++;
        if ({s0_if.ready, s1_if.ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b%b exp 00", s0_if.ready, s1_if.ready);
        end
        checks++;
        if ({busy, active_src} !== 2'b00) begin
            errors++; $display("FAIL reset_busy_src got %b%b exp 00", busy, active_src);
        end
        checks++;
        if (frame_count !== 16'd0) begin
            errors++; $display("FAIL reset_fc got %0d exp 0", frame_count);
        end
    endtask

    task automatic test_fixed_pass();
        bit ok; int d;
        do_reset();
        gap0 = 1; bp_en = 1'b1;
        gen_pkt(1'b0, 4'hF, 4); push_pkt(1'b0);
        gen_pkt(1'b0, 4'h0, 16); pkt[0].data = '0; push_pkt(1'b0);
        cfg_enable = 1'b1;
        wait_out(20, 2000, ok);
        tick(); tick(); tick();
        checks++;
        if (!ok) begin errors++; $display("FAIL fixed_timeout got %0d beats exp 20", out_cnt); end
        d = first_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL fixed_seq diff at %0d got %0d beats exp %0d", d, out_q.size(), exp_q.size()); end
        checks++;
        if (frame_count !== 16'd1) begin errors++; $display("FAIL fixed_fc got %0d exp 1", frame_count); end
        checks++;
        if (active_src !== 1'b0 || s1_rdy_any) begin
            errors++; $display("FAIL fixed_src got src=%b s1_ready_seen=%b exp 0 0", active_src, s1_rdy_any);
        end
    endtask

    task automatic test_switch_fixed();
        bit ok, found; int d;
        do_reset();
        gap0 = 1;
        gen_pkt(1'b0, 4'h0, 16); push_pkt(1'b0);
        gen_pkt(1'b1, 4'h0, 6);  push_pkt(1'b1);
        cfg_enable = 1'b1;
        wait_out(9, 500, ok);
        #2 cfg_sel = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (m_if.valid && m_if.eop) begin found = 1'b1; break; end
        end
        checks++;
        if (!ok || !found) begin errors++; $display("FAIL switch_eop_timeout got ok=%b found=%b exp 1 1", ok, found); end
        @(negedge clk);
        checks++;
        if ({busy, s0_if.ready, s1_if.ready, active_src, m_if.valid} !== 5'b10000) begin
            errors++; $display("FAIL switch_drain got busy/r0/r1/src/v=%b%b%b%b%b exp 10000", busy, s0_if.ready, s1_if.ready, active_src, m_if.valid);
        end
        @(negedge clk);
        checks++;
        if ({busy, s0_if.ready, s1_if.ready, m_if.valid} !== 4'b0000) begin
            errors++; $display("FAIL switch_idle got busy/r0/r1/v=%b%b%b%b exp 0000", busy, s0_if.ready, s1_if.ready, m_if.valid);
        end
        @(negedge clk);
        checks++;
        if ({s0_if.ready, s1_if.ready, active_src} !== 3'b011) begin
            errors++; $display("FAIL switch_grant got r0/r1/src=%b%b%b exp 011", s0_if.ready, s1_if.ready, active_src);
        end
        checks++;
        if (frame_count !== 16'd1) begin errors++; $display("FAIL switch_fc1 got %0d exp 1", frame_count); end
        #2 m_if.ready = 1'b0;
        @(negedge clk);
        checks++;
        if (s1_if.ready !== 1'b0) begin errors++; $display("FAIL switch_track got %b exp 0", s1_if.ready); end
        tick(); m_if.ready = 1'b1;
        wait_out(22, 500, ok);
        tick(); tick(); tick();
        d = first_diff();
        checks++;
        if (!ok || d != -1) begin errors++; $display("FAIL switch_seq ok=%b diff at %0d got %0d beats exp %0d", ok, d, out_q.size(), exp_q.size()); end
        checks++;
        if (frame_count !== 16'd2) begin errors++; $display("FAIL switch_fc2 got %0d exp 2", frame_count); end
    endtask

    task automatic test_alternate();
        bit ok; int d, f; bit exp_src;
        do_reset();
        gap0 = 1; gap1 = 1; bp_en = 1'b1; cfg_mode = 1'b1;
        // Reference: slots of FPS frames, sources alternating from source 0.
        for (int slot = 0; slot < 3; slot++) begin
            for (int k = 0; k < FPS; k++) begin
                gen_pkt(1'(slot % 2), 4'hF, $urandom_range(1, 4)); push_pkt(1'(slot % 2));
                gen_pkt(1'(slot % 2), 4'h0, $urandom_range(2, 9)); push_pkt(1'(slot % 2));
            end
        end
        cfg_enable = 1'b1;
        wait_out(exp_q.size(), 5000, ok);
        for (int i = 0; i < 6; i++) tick();
        d = first_diff();
        checks++;
        if (!ok || d != -1) begin errors++; $display("FAIL alt_seq ok=%b diff at %0d got %0d beats exp %0d", ok, d, out_q.size(), exp_q.size()); end
        f = 0;
        foreach (out_q[i]) begin
            if (out_q[i].sop && out_q[i].data[3:0] == 4'h0) begin
                exp_src = 1'(((f / FPS) % 2));
                checks++;
                if (out_q[i].data[23] !== exp_src) begin
                    errors++; $display("FAIL alt_frame%0d_src got %b exp %b", f, out_q[i].data[23], exp_src);
                end
                f++;
            end
        end
        checks++;
        if (frame_count !== 16'd6 || f != 6) begin errors++; $display("FAIL alt_fc got %0d frames=%0d exp 6", frame_count, f); end
        checks++;
        if (both_rdy) begin errors++; $display("FAIL alt_both_ready got 1 exp 0"); end
    endtask

    task automatic test_drain_sop();
        bit ok; int d;
        do_reset();
        gap0 = 0;
        gen_pkt(1'b0, 4'h0, 6); push_pkt(1'b0);
        gen_pkt(1'b0, 4'hF, 3); push_pkt(1'b0);
        gen_pkt(1'b0, 4'h0, 5); push_pkt(1'b0);
        gen_pkt(1'b1, 4'h0, 4); push_pkt(1'b1);
        cfg_enable = 1'b1;
        wait_out(2, 200, ok);
        #2 cfg_sel = 1'b1;
        wait_out(18, 500, ok);
        tick(); tick(); tick();
        d = first_diff();
        checks++;
        if (!ok || d != -1) begin errors++; $display("FAIL drain_seq ok=%b diff at %0d got %0d beats exp %0d", ok, d, out_q.size(), exp_q.size()); end
        checks++;
        if (!drain_beat) begin errors++; $display("FAIL drain_beat_fwd got 0 exp 1"); end
        checks++;
        if (frame_count !== 16'd3 || active_src !== 1'b1) begin
            errors++; $display("FAIL drain_end got fc=%0d src=%b exp 3 1", frame_count, active_src);
        end
    endtask

    task automatic test_disable();
        bit ok; int d;
        do_reset();
        gap0 = 1;
        gen_pkt(1'b0, 4'h0, 10); push_pkt(1'b0);
        cfg_enable = 1'b1;
        wait_out(3, 200, ok);
        #2 cfg_enable = 1'b0;
        wait_out(10, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL dis_frame_complete got %0d beats exp 10", out_cnt); end
        gen_pkt(1'b1, 4'h0, 5); push_pkt(1'b1);
        cfg_sel = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        checks++;
        if ({busy, m_if.valid, s0_if.ready, s1_if.ready} !== 4'b0000) begin
            errors++; $display("FAIL dis_idle got busy/v/r0/r1=%b%b%b%b exp 0000", busy, m_if.valid, s0_if.ready, s1_if.ready);
        end
        checks++;
        if (out_cnt != 10) begin errors++; $display("FAIL dis_no_fwd got %0d beats exp 10", out_cnt); end
        tick(); cfg_enable = 1'b1;
        wait_out(15, 300, ok);
        tick(); tick();
        checks++;
        if (active_src !== 1'b1) begin errors++; $display("FAIL dis_regrant got %b exp 1", active_src); end
        d = first_diff();
        checks++;
        if (!ok || d != -1 || frame_count !== 16'd2) begin
            errors++; $display("FAIL dis_seq ok=%b diff=%0d fc=%0d exp -1 2", ok, d, frame_count);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        gap0 = 0;
        gen_pkt(1'b0, 4'h0, 4);  push_pkt(1'b0);
        gen_pkt(1'b0, 4'h0, 20); push_pkt(1'b0);
        cfg_enable = 1'b1;
        wait_out(8, 200, ok);
        #2;
        checks++;
        if (!ok || frame_count !== 16'd1) begin errors++; $display("FAIL rst_pre got ok=%b fc=%0d exp 1 1", ok, frame_count); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_if.valid, s0_if.ready, s1_if.ready, busy} !== 4'b0000) begin
            errors++; $display("FAIL rst_mid got v/r0/r1/busy=%b%b%b%b exp 0000", m_if.valid, s0_if.ready, s1_if.ready, busy);
        end
        checks++;
        if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_mid_fc got %0d exp 0", frame_count); end
    endtask

    task automatic test_fc_wrap();
        bit ok; beat_t b;
        do_reset();
        gap0 = 0;
        b.data = 24'h0; b.sop = 1'b1; b.eop = 1'b1;
        for (int i = 0; i < 65535; i++) q0.push_back(b);
        cfg_enable = 1'b1;
        wait_out(65535, 70000, ok);
        tick(); tick();
        checks++;
        if (!ok || frame_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got ok=%b fc=%h exp 1 ffff", ok, frame_count); end
        q0.push_back(b);
        wait_out(65536, 100, ok);
        tick(); tick();
        checks++;
        if (!ok || frame_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got ok=%b fc=%h exp 1 0000", ok, frame_count); end
    endtask

    initial begin
        s0_if.valid = 1'b0; s0_if.sop = 1'b0; s0_if.eop = 1'b0; s0_if.data = '0;
        s1_if.valid = 1'b0; s1_if.sop = 1'b0; s1_if.eop = 1'b0; s1_if.data = '0;
        test_reset();
        test_fixed_pass();
        test_switch_fixed();
        test_alternate();
        test_drain_sop();
        test_disable();
        test_reset_mid();
        test_fc_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
